// File: rtl/ama_riscv_mem_rsp_if.sv
// rv_if: generic valid/ready/data handshake bundle.
//   valid : producer has data this cycle
//   ready : consumer can take data this cycle
//   data  : payload, DW bits wide
// Modports: TX (producer side), RX (consumer side).
interface rv_if #(
    parameter int DW = 32
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport TX (output valid, output data, input ready);
    modport RX (input valid, input data, output ready);
endinterface

// File: rtl/ama_riscv_mem_rsp.sv
// ama_riscv_mem_rsp: main-memory responder for the instruction-side refill
// path. Accepts block addresses on req, returns block data on rsp in order,
// with fixed latency and a bounded number of outstanding requests.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req (rv_if.RX): MEM_ADDR_BUS-wide block address requests
//   rsp (rv_if.TX): MEM_DATA_BUS-wide block data responses
//   ld_en/ld_addr/ld_data : preload write port into storage
//   err           : sticky flag, set when a request addresses >= DEPTH
//
// Optional feature (macro MEM_RSP_PERF_CNT_EN): adds 32-bit counters
//   perf_req_cnt (request accepts), perf_rsp_cnt (response consumes),
//   perf_bp_cnt (cycles with rsp.valid && !rsp.ready).
module ama_riscv_mem_rsp #(
    parameter int DEPTH        = 1024,
    parameter int LATENCY      = 1,
    parameter int OUT_DEPTH    = 4,
    parameter int MEM_ADDR_BUS = 32,
    parameter int MEM_DATA_BUS = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    rv_if.RX                         req,
    rv_if.TX                         rsp,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [MEM_DATA_BUS-1:0]  ld_data,
    output logic                     err
`ifdef MEM_RSP_PERF_CNT_EN
    ,
    output logic [31:0]              perf_req_cnt,
    output logic [31:0]              perf_rsp_cnt,
    output logic [31:0]              perf_bp_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam logic [CW-1:0]           CNT_MAX  = CW'(OUT_DEPTH);
    localparam logic [PW-1:0]           PTR_LAST = PW'(OUT_DEPTH - 1);
    localparam logic [MEM_ADDR_BUS-1:0] DEPTH_A  = MEM_ADDR_BUS'(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("ama_riscv_mem_rsp: DEPTH must be a power of 2");
        end
        if (LATENCY < 1) begin : g_bad_latency
            $error("ama_riscv_mem_rsp: LATENCY must be >= 1");
        end
        if (OUT_DEPTH < LATENCY) begin : g_bad_out_depth
            $error("ama_riscv_mem_rsp: OUT_DEPTH must be >= LATENCY");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshakes and address decode
    // ------------------------------------------------------------------
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [MEM_DATA_BUS-1:0] rsp_data_q, rsp_data_d;
    logic                    err_q, err_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [MEM_ADDR_BUS-1:0] req_addr_s;
    logic [AW-1:0]           req_idx_s;
    logic                    req_oor_s;
    logic                    req_acc_s;
    logic                    rsp_cons_s;

    assign req_addr_s = req.data;
    assign req_idx_s  = req_addr_s[AW-1:0];
    assign req_oor_s  = (req_addr_s >= DEPTH_A);
    assign req_acc_s  = req.valid && req_ready_q;
    assign rsp_cons_s = rsp_valid_q && rsp.ready;

    // ------------------------------------------------------------------
    // Delay line: LATENCY-1 stages of (valid, index, out-of-range) ahead
    // of the array read, so the read lands exactly LATENCY edges after
    // the accept.
    // ------------------------------------------------------------------
    logic          rd_v_s;
    logic [AW-1:0] rd_idx_s;
    logic          rd_oor_s;

    generate
        if (LATENCY == 1) begin : g_no_dly
            assign rd_v_s   = req_acc_s;
            assign rd_idx_s = req_idx_s;
            assign rd_oor_s = req_oor_s;
        end else begin : g_dly
            localparam int NS = LATENCY - 1;
            logic [NS-1:0] dv_q, dv_d;
            logic [NS-1:0] door_q, door_d;
            logic [AW-1:0] didx_q [NS];
            logic [AW-1:0] didx_d [NS];

            // Shift the request one stage down the delay line.
            always_comb begin
                dv_d[0]   = req_acc_s;
                door_d[0] = req_oor_s;
                didx_d[0] = req_idx_s;
                for (int i = 1; i < NS; i++) begin
                    dv_d[i]   = dv_q[i-1];
                    door_d[i] = door_q[i-1];
                    didx_d[i] = didx_q[i-1];
                end
            end

            // Delay-line registers; reset empties the valid bits only.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dv_q <= '0;
                end else begin
                    dv_q   <= dv_d;
                    door_q <= door_d;
                    didx_q <= didx_d;
                end
            end

            assign rd_v_s   = dv_q[NS-1];
            assign rd_idx_s = didx_q[NS-1];
            assign rd_oor_s = door_q[NS-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage. Not reset: preloaded contents survive rst. The read value
    // is only ever captured into flops on the same edge as a preload
    // write, so a same-index collision returns the old contents.
    // ------------------------------------------------------------------
    logic [MEM_DATA_BUS-1:0] mem_q [DEPTH];
    logic [MEM_DATA_BUS-1:0] rd_data_s;

    // Preload write port.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    assign rd_data_s = rd_oor_s ? '0 : mem_q[rd_idx_s];

    // ------------------------------------------------------------------
    // In-order response queue behind the rsp output register. Read data
    // goes straight into the output register when it is free and the
    // queue is empty, so there is no bubble on the fast path.
    // ------------------------------------------------------------------
    logic [MEM_DATA_BUS-1:0] fifo_q [OUT_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                    wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
    logic                    fifo_empty_s;
    logic                    push_s, pop_s;

    // Equal pointers with equal wrap bits means empty.
    assign fifo_empty_s = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q == rd_wrap_q);

    // Output register / queue steering.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (!rsp_valid_q || rsp_cons_s) begin
            if (!fifo_empty_s) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = fifo_q[rd_ptr_q];
                pop_s       = 1'b1;
                push_s      = rd_v_s;
            end else if (rd_v_s) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = rd_data_s;
            end else begin
                rsp_valid_d = 1'b0;
            end
        end else begin
            push_s = rd_v_s;
        end
    end

    // Queue pointer advance, wrapping modulo OUT_DEPTH.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_wrap_d = wr_wrap_q;
        rd_ptr_d  = rd_ptr_q;
        rd_wrap_d = rd_wrap_q;
        if (push_s) begin
            if (wr_ptr_q == PTR_LAST) begin
                wr_ptr_d  = '0;
                wr_wrap_d = ~wr_wrap_q;
            end else begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            if (rd_ptr_q == PTR_LAST) begin
                rd_ptr_d  = '0;
                rd_wrap_d = ~rd_wrap_q;
            end else begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Queue storage; entries are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_q[wr_ptr_q] <= rd_data_s;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding count, registered ready and sticky error
    // ------------------------------------------------------------------
    always_comb begin
        case ({req_acc_s, rsp_cons_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // Ready follows the next count so a full responder never accepts.
        req_ready_d = (cnt_d < CNT_MAX);
        if (req_acc_s && req_oor_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_wrap_q   <= 1'b0;
            rd_wrap_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_wrap_q   <= wr_wrap_d;
            rd_wrap_q   <= rd_wrap_d;
        end
    end

    assign req.ready = req_ready_q;
    assign rsp.valid = rsp_valid_q;
    assign rsp.data  = rsp_data_q;
    assign err       = err_q;

`ifdef MEM_RSP_PERF_CNT_EN
    logic [31:0] perf_req_q, perf_req_d;
    logic [31:0] perf_rsp_q, perf_rsp_d;
    logic [31:0] perf_bp_q, perf_bp_d;

    // Event counters; they wrap naturally at 2^32.
    always_comb begin
        perf_req_d = perf_req_q + (req_acc_s ? 32'd1 : 32'd0);
        perf_rsp_d = perf_rsp_q + (rsp_cons_s ? 32'd1 : 32'd0);
        perf_bp_d  = perf_bp_q + ((rsp_valid_q && !rsp.ready) ? 32'd1 : 32'd0);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_req_q <= 32'd0;
            perf_rsp_q <= 32'd0;
            perf_bp_q  <= 32'd0;
        end else begin
            perf_req_q <= perf_req_d;
            perf_rsp_q <= perf_rsp_d;
            perf_bp_q  <= perf_bp_d;
        end
    end

    assign perf_req_cnt = perf_req_q;
    assign perf_rsp_cnt = perf_rsp_q;
    assign perf_bp_cnt  = perf_bp_q;
`endif

endmodule

// File: tb/tb_ama_riscv_mem_rsp.sv
module tb_ama_riscv_mem_rsp;

    localparam int DW    = 128;
    localparam int ABW   = 32;
    localparam int DEPTH = 1024;
    localparam int IW    = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            ld_en;
    logic [IW-1:0]   ld_addr;
    logic [DW-1:0]   ld_data;
    logic            err1, err3;

    rv_if #(.DW(ABW)) req1 ();
    rv_if #(.DW(DW))  rsp1 ();
    rv_if #(.DW(ABW)) req3 ();
    rv_if #(.DW(DW))  rsp3 ();

`ifdef MEM_RSP_PERF_CNT_EN
    logic [31:0] p1_req, p1_rsp, p1_bp, p3_req, p3_rsp, p3_bp;
`endif

    ama_riscv_mem_rsp #(.DEPTH(DEPTH), .LATENCY(1), .OUT_DEPTH(4),
                        .MEM_ADDR_BUS(ABW), .MEM_DATA_BUS(DW)) u_dut (
        .clk(clk), .rst(rst), .req(req1), .rsp(rsp1),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err(err1)
`ifdef MEM_RSP_PERF_CNT_EN
        , .perf_req_cnt(p1_req), .perf_rsp_cnt(p1_rsp), .perf_bp_cnt(p1_bp)
`endif
    );

    ama_riscv_mem_rsp #(.DEPTH(DEPTH), .LATENCY(3), .OUT_DEPTH(4),
                        .MEM_ADDR_BUS(ABW), .MEM_DATA_BUS(DW)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .rsp(rsp3),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err(err3)
`ifdef MEM_RSP_PERF_CNT_EN
        , .perf_req_cnt(p3_req), .perf_rsp_cnt(p3_rsp), .perf_bp_cnt(p3_bp)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int acc_cnt  = 0;
    int cons_cnt = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] sb_q [$];

    task automatic chk_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(i);
        return {4{w}};
    endfunction

    // Scoreboard monitor on the LATENCY=1 instance, sampled mid-cycle.
    always @(negedge clk) begin
        logic [DW-1:0] exp_v;
        cyc++;
        if (!rst) begin
            if (req1.valid && req1.ready) begin
                acc_cnt++;
                if (req1.data >= ABW'(DEPTH)) sb_q.push_back('0);
                else sb_q.push_back(model_mem[req1.data[IW-1:0]]);
            end
            if (rsp1.valid && rsp1.ready) begin
                cons_cnt++;
                if (sb_q.size() == 0) begin
                    chk_eq("sb_unexpected_rsp", 128'd1, 128'd0);
                end else begin
                    exp_v = sb_q.pop_front();
                    chk_eq("rsp_data", rsp1.data, exp_v);
                end
            end
        end
        // Storage update after the read sample: same-edge reads see old data.
        if (ld_en) model_mem[ld_addr] = ld_data;
    end

    task automatic preload(input int a, input logic [DW-1:0] d);
        ld_en = 1'b1; ld_addr = IW'(a); ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Present one request and hold it until the handshake edge has passed.
    task automatic issue(input bit d3, input logic [31:0] a);
        bit done;
        done = 1'b0;
        if (d3) begin req3.valid = 1'b1; req3.data = a; end
        else begin req1.valid = 1'b1; req1.data = a; end
        for (int n = 0; n < 200 && !done; n++) begin
            done = d3 ? req3.ready : req1.ready;
            @(posedge clk); #1;
        end
        if (!done) chk_eq("req_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 100; n++) begin
            if (sb_q.size() == 0 && !rsp1.valid) break;
            @(posedge clk); #1;
        end
        chk_eq("drain", 128'(sb_q.size()), 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, c0, a0, n;
        bit seen;
        rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        req1.valid = 1'b0; req1.data = '0; rsp1.ready = 1'b0;
        req3.valid = 1'b0; req3.data = '0; rsp3.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_req_ready", 128'(req1.ready), 128'd0);
        chk_eq("rst_rsp_valid", 128'(rsp1.valid), 128'd0);
        chk_eq("rst_rsp_data", rsp1.data, 128'd0);
        chk_eq("rst_err", 128'(err1), 128'd0);
        chk_eq("rst_rsp3_valid", 128'(rsp3.valid), 128'd0);

        // Preload while still in reset: storage is independent of rst.
        preload(16'h10, {16{8'hA5}});
        for (int i = 0; i < 4; i++) preload(16'h20 + i, pat(i));
        preload(16'h05, {16{8'h11}});
        preload(16'h30, {4{32'h3030_3030}});
        preload(16'h31, {4{32'h3131_3131}});

        rst = 1'b0;
        @(posedge clk); #1;
        chk_eq("ready_after_rst", 128'(req1.ready), 128'd1);

        // 1: single request, exactly one cycle of latency.
        rsp1.ready = 1'b1;
        chk_eq("t1_idle", 128'(rsp1.valid), 128'd0);
        issue(1'b0, 32'h10);
        req1.valid = 1'b0;
        chk_eq("t1_lat_valid", 128'(rsp1.valid), 128'd1);
        chk_eq("t1_data", rsp1.data, {16{8'hA5}});
        chk_eq("t1_err", 128'(err1), 128'd0);
        wait_drain();

        // 2: line fill, four back-to-back requests and responses.
        t0 = cyc; c0 = cons_cnt;
        for (int i = 0; i < 4; i++) issue(1'b0, 32'h20 + 32'(i));
        req1.valid = 1'b0;
        chk_eq("t2_req_b2b", 128'(cyc - t0), 128'd4);
        @(negedge clk); #1;
        chk_eq("t2_rsp_b2b", 128'(cons_cnt - c0), 128'd4);
        wait_drain();

        // 3: backpressure with OUT_DEPTH=4 and six offered requests.
        rsp1.ready = 1'b0;
        a0 = acc_cnt;
        fork
            begin
                issue(1'b0, 32'h20); issue(1'b0, 32'h21); issue(1'b0, 32'h22);
                issue(1'b0, 32'h23); issue(1'b0, 32'h10); issue(1'b0, 32'h20);
                req1.valid = 1'b0;
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                chk_eq("t3_accepted", 128'(acc_cnt - a0), 128'd4);
                chk_eq("t3_ready_low", 128'(req1.ready), 128'd0);
                chk_eq("t3_hold_valid", 128'(rsp1.valid), 128'd1);
                chk_eq("t3_hold_data", rsp1.data, pat(0));
                rsp1.ready = 1'b1;
            end
        join
        wait_drain();
        chk_eq("t3_total", 128'(acc_cnt - a0), 128'd6);

        // 4: out-of-range address returns zero and sets sticky err.
        issue(1'b0, 32'h400);
        req1.valid = 1'b0;
        chk_eq("t4_err_set", 128'(err1), 128'd1);
        chk_eq("t4_data_zero", rsp1.data, 128'd0);
        issue(1'b0, 32'h10); issue(1'b0, 32'h21);
        req1.valid = 1'b0;
        wait_drain();
        chk_eq("t4_err_sticky", 128'(err1), 128'd1);

        // 5: preload and read of the same index on the same edge.
        ld_en = 1'b1; ld_addr = IW'(5); ld_data = {16{8'hFF}};
        issue(1'b0, 32'h05);
        ld_en = 1'b0;
        req1.valid = 1'b0;
        chk_eq("t5_old", rsp1.data, {16{8'h11}});
        @(posedge clk); #1;
        issue(1'b0, 32'h05);
        req1.valid = 1'b0;
        chk_eq("t5_new", rsp1.data, {16{8'hFF}});
        wait_drain();

        // 6: reset with two requests in flight on the LATENCY=3 instance.
        rsp3.ready = 1'b1;
        issue(1'b1, 32'h30); issue(1'b1, 32'h31);
        req3.valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_eq("t6_ready3", 128'(req3.ready), 128'd1);
        chk_eq("t6_ready1", 128'(req1.ready), 128'd1);
        chk_eq("t6_err_clr", 128'(err1), 128'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | rsp3.valid;
        end
        @(posedge clk); #1;
        chk_eq("t6_no_stale_rsp", 128'(seen), 128'd0);
        issue(1'b1, 32'h30);
        req3.valid = 1'b0;
        n = 1;
        while (!rsp3.valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq("t6_latency", 128'(n), 128'd3);
        chk_eq("t6_data", rsp3.data, {4{32'h3030_3030}});
        @(posedge clk); #1;

        chk_eq("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
